// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential integer divider.
package div_pkg;

  // Divider control states.
  typedef enum logic [2:0] {
    IDLE,
    PREPARE,
    EXECUTE,
    FIXUP,
    WRITEBACK
  } div_state_e;

  // The iteration counter and the leading-zero count both have to represent
  // the value WIDTH itself, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_param_lzc.sv
// Combinational leading-zero count; an all-zero input reports WIDTH.
module lzc_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]            i_data,
  output logic [cnt_width(WIDTH)-1:0] o_count
);

  localparam int CW = cnt_width(WIDTH);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/divider_param.sv
// Sequential restoring divider, unsigned or two's-complement signed, with
// RISC-V results for divide-by-zero and signed overflow. Leading zeros of the
// dividend are skipped so only significant bits are iterated.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// IDLE      | ready for a request; operands latched on start_i
// PREPARE   | form magnitudes, normalise dividend, catch zero/overflow cases
// EXECUTE   | one shift/subtract step per cycle, n steps total
// FIXUP     | apply result signs for signed operations
// WRITEBACK | load output registers and pulse valid_o
module divider_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             error_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       r_state;
  logic             r_sgn;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic             r_valid;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_err_o;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [CW-1:0]    w_lzc;
  logic [CW-1:0]    w_n;
  logic [WIDTH:0]   w_p_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_b_zero;
  logic             w_ovf;

  // Operand signs only matter for signed requests, so unsigned FIXUP is a no-op.
  assign w_a_neg   = r_sgn & r_a[WIDTH-1];
  assign w_b_neg   = r_sgn & r_b[WIDTH-1];
  assign w_a_abs   = w_a_neg ? -r_a : r_a;
  assign w_b_abs   = w_b_neg ? -r_b : r_b;
  assign w_n       = CW'(WIDTH) - w_lzc;
  assign w_b_zero  = (r_b == '0);
  assign w_ovf     = r_sgn && (r_a == MOST_NEG) && (&r_b);

  // The remainder never exceeds |B|-1, so P' fits in WIDTH+1 bits and a
  // non-negative difference always fits back into WIDTH bits.
  assign w_p_shift = {r_p, r_dvd[WIDTH-1]};
  assign w_diff    = w_p_shift - {1'b0, w_b_abs};

  lzc_param #(.WIDTH(WIDTH)) u_lzc (
    .i_data  (w_a_abs),
    .o_count (w_lzc)
  );

  // Divider FSM with datapath registers and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_sgn   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_dvd   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_err_o <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (abort_i && (r_state != IDLE)) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_i) begin
              r_a     <= a_i;
              r_b     <= b_i;
              r_sgn   <= signed_i;
              r_state <= PREPARE;
            end
          end
          PREPARE: begin
            r_dvd <= w_a_abs << w_lzc;
            r_p   <= '0;
            r_q   <= '0;
            r_cnt <= w_n;
            r_err <= 1'b0;
            if (w_b_zero) begin
              r_q     <= '1;
              r_p     <= r_a;
              r_err   <= 1'b1;
              r_state <= WRITEBACK;
            end else if (w_ovf) begin
              r_q     <= r_a;
              r_state <= WRITEBACK;
            end else if (w_n == '0) begin
              r_state <= FIXUP;
            end else begin
              r_state <= EXECUTE;
            end
          end
          EXECUTE: begin
            r_dvd <= r_dvd << 1;
            r_p   <= w_diff[WIDTH] ? w_p_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_state <= FIXUP;
          end
          FIXUP: begin
            if (w_a_neg ^ w_b_neg) r_q <= -r_q;
            if (w_a_neg)           r_p <= -r_p;
            r_state <= WRITEBACK;
          end
          WRITEBACK: begin
            r_quot  <= r_q;
            r_rem   <= r_p;
            r_err_o <= r_err;
            r_valid <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ready_o     = (r_state == IDLE);
  assign valid_o     = r_valid;
  assign quotient_o  = r_quot;
  assign remainder_o = r_rem;
  assign error_o     = r_err_o;

endmodule

// File: tb/tb_divider_param.sv
// Self-checking bench for divider_param at WIDTH=32 and WIDTH=8.
module tb_divider_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, abort;
  logic        start32, sgn32, rdy32, vld32, err32;
  logic [31:0] a32, b32, q32, r32;
  logic        start8, sgn8, rdy8, vld8, err8;
  logic [7:0]  a8, b8, q8, r8;

  int checks = 0;
  int errors = 0;

  divider_param #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start32), .signed_i(sgn32), .abort_i(abort),
    .a_i(a32), .b_i(b32), .ready_o(rdy32), .valid_o(vld32),
    .quotient_o(q32), .remainder_o(r32), .error_o(err32)
  );

  divider_param #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .signed_i(sgn8), .abort_i(abort),
    .a_i(a8), .b_i(b8), .ready_o(rdy8), .valid_o(vld8),
    .quotient_o(q8), .remainder_o(r8), .error_o(err8)
  );

  typedef struct {
    int          w;
    bit          sgn;
    logic [63:0] a, b, q, r;
    bit          err;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: RISC-V division semantics from plain integer arithmetic.
  function automatic void ref_div(input int w, input bit sgn, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q,
                                  output logic [63:0] r, output bit err, output int lat);
    longint mask = (longint'(1) << w) - 1;
    longint ua = longint'(a) & mask;
    longint ub = longint'(b) & mask;
    longint sa = ua;
    longint sb = ub;
    longint mag;
    int n;
    if (sgn && ((ua >> (w - 1)) & 1) == 1) sa = ua - (longint'(1) << w);
    if (sgn && ((ub >> (w - 1)) & 1) == 1) sb = ub - (longint'(1) << w);
    err = 0;
    if (ub == 0) begin
      q = 64'(mask); r = 64'(ua); err = 1; lat = 3;
    end else if (sgn && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
      q = 64'(ua); r = 0; lat = 3;
    end else begin
      if (sgn) begin
        q = 64'((sa / sb) & mask);
        r = 64'((sa % sb) & mask);
      end else begin
        q = 64'(ua / ub);
        r = 64'(ua % ub);
      end
      mag = (sa < 0) ? -sa : sa;
      n = 0;
      while (mag > 0) begin
        mag = mag / 2;
        n++;
      end
      lat = n + 4;
    end
  endfunction

  // Issue one request (accepted on the next rising edge) and wait for valid_o.
  // lat counts edges from the accepting edge (1) to the edge that raises valid_o.
  task automatic do_op(input int w, input bit sgn, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] q, output logic [63:0] r, output bit err,
                       output int lat);
    bit got;
    if (w == 32) begin start32 = 1; sgn32 = sgn; a32 = a[31:0]; b32 = b[31:0]; end
    else         begin start8  = 1; sgn8  = sgn; a8  = a[7:0];  b8  = b[7:0];  end
    @(posedge clk); #1;
    start32 = 0; start8 = 0;
    a32 = $urandom(); b32 = $urandom(); a8 = 8'($urandom()); b8 = 8'($urandom());
    lat = 1;
    got = (w == 32) ? vld32 : vld8;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      got = (w == 32) ? vld32 : vld8;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout w=%0d a=0x%0h b=0x%0h: no valid_o within %0d cycles", w, a, b, lat);
    end
    if (w == 32) begin q = 64'(q32); r = 64'(r32); err = err32; chk("ready_at_valid32", 64'(rdy32), 1); end
    else         begin q = 64'(q8);  r = 64'(r8);  err = err8;  chk("ready_at_valid8", 64'(rdy8), 1); end
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] q, r;
    bit err;
    int lat;
    string tag;
    do_op(v.w, v.sgn, v.a, v.b, q, r, err, lat);
    tag = $sformatf("w%0d s%0d 0x%0h/0x%0h", v.w, v.sgn, v.a, v.b);
    chk({tag, " quotient"}, q, v.q);
    chk({tag, " remainder"}, r, v.r);
    chk({tag, " error"}, 64'(err), 64'(v.err));
    chk({tag, " latency"}, 64'(lat), 64'(v.lat));
  endtask

  task automatic run_rand(input int w, input bit sgn, input logic [63:0] a, input logic [63:0] b);
    vec_t v;
    v.w = w; v.sgn = sgn; v.a = a; v.b = b;
    ref_div(w, sgn, a, b, v.q, v.r, v.err, v.lat);
    run_vec(v);
  endtask

  initial begin
    bit saw_valid;
    logic [63:0] ra, rb;

    rst = 1; abort = 0;
    start32 = 0; sgn32 = 0; a32 = 0; b32 = 0;
    start8 = 0; sgn8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready32", 64'(rdy32), 1);
    chk("reset valid32", 64'(vld32), 0);
    chk("reset q32", 64'(q32), 0);
    chk("reset r32", 64'(r32), 0);
    chk("reset err32", 64'(err32), 0);
    chk("reset ready8", 64'(rdy8), 1);
    rst = 0;
    @(posedge clk); #1;

    //                w   s  a                  b                  q                  r                  e  lat
    tbl.push_back('{32, 0, 64'd100,           64'd7,             64'd14,            64'd2,             0, 11});
    tbl.push_back('{32, 1, 64'hFFFF_FFF9,     64'd2,             64'hFFFF_FFFD,     64'hFFFF_FFFF,     0, 7});
    tbl.push_back('{32, 1, 64'd7,             64'hFFFF_FFFE,     64'hFFFF_FFFD,     64'd1,             0, 7});
    tbl.push_back('{32, 0, 64'h1234,          64'd0,             64'hFFFF_FFFF,     64'h1234,          1, 3});
    tbl.push_back('{32, 1, 64'h8000_0000,     64'hFFFF_FFFF,     64'h8000_0000,     64'd0,             0, 3});
    tbl.push_back('{32, 0, 64'd0,             64'd5,             64'd0,             64'd0,             0, 4});
    tbl.push_back('{32, 1, 64'd0,             64'hFFFF_FFFF,     64'd0,             64'd0,             0, 4});
    tbl.push_back('{32, 0, 64'hFFFF_FFFF,     64'd1,             64'hFFFF_FFFF,     64'd0,             0, 36});
    tbl.push_back('{32, 0, 64'h8000_0000,     64'hFFFF_FFFF,     64'd0,             64'h8000_0000,     0, 36});
    tbl.push_back('{8,  0, 64'd255,           64'd1,             64'd255,           64'd0,             0, 12});
    tbl.push_back('{8,  1, 64'h80,            64'hFF,            64'h80,            64'd0,             0, 3});
    tbl.push_back('{8,  1, 64'h80,            64'd2,             64'hC0,            64'd0,             0, 12});
    tbl.push_back('{8,  0, 64'd0,             64'd0,             64'hFF,            64'd0,             1, 3});
    // Consecutive entries also exercise acceptance in the valid_o cycle.
    tbl.push_back('{32, 0, 64'd1000,          64'd10,            64'd100,           64'd0,             0, 14});
    tbl.push_back('{32, 1, 64'hFFFF_FF9C,     64'd7,             64'hFFFF_FFF2,     64'hFFFF_FFFE,     0, 11});
    tbl.push_back('{32, 0, 64'd100,           64'd7,             64'd14,            64'd2,             0, 11});

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Abort in the middle of a 32-iteration divide; outputs keep 14/2.
    saw_valid = 0;
    start32 = 1; sgn32 = 0; a32 = 32'hFFFF_FFFF; b32 = 32'd3;
    @(posedge clk); #1;
    start32 = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (vld32) saw_valid = 1;
    end
    chk("busy before abort", 64'(rdy32), 0);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort ready", 64'(rdy32), 1);
    chk("abort valid", 64'(vld32), 0);
    repeat (40) begin
      @(posedge clk); #1;
      if (vld32) saw_valid = 1;
    end
    chk("abort no valid pulse", 64'(saw_valid), 0);
    chk("abort holds q", 64'(q32), 14);
    chk("abort holds r", 64'(r32), 2);
    chk("abort holds err", 64'(err32), 0);

    // Reset while in EXECUTE clears outputs immediately.
    start32 = 1; sgn32 = 0; a32 = 32'hFFFF_FFFF; b32 = 32'd3;
    @(posedge clk); #1;
    start32 = 0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("midrst ready", 64'(rdy32), 1);
    chk("midrst valid", 64'(vld32), 0);
    chk("midrst q", 64'(q32), 0);
    chk("midrst r", 64'(r32), 0);
    chk("midrst err", 64'(err32), 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 64'($urandom() >> $urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0:       rb = 0;
        1:       rb = 64'hFFFF_FFFF;
        2:       rb = 64'($urandom_range(1, 15));
        default: rb = 64'($urandom() >> $urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 15) == 0) ra = 64'h8000_0000;
      run_rand(32, bit'($urandom_range(0, 1)), ra, rb);
    end
    for (int i = 0; i < 30; i++) begin
      ra = 64'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin ra = 64'h80; rb = 64'hFF; end
      run_rand(8, bit'($urandom_range(0, 1)), ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_param.md
# divider_param

Parametrised sequential restoring integer divider: WIDTH-bit dividend by WIDTH-bit divisor, unsigned or two's-complement signed, with RISC-V M-extension results for divide-by-zero and signed overflow. The shift/subtract loop skips the dividend's leading zeros, so it iterates only over significant bits. It is the next-generation integer divide unit for the core's execute stage, with a start/ready/valid handshake and an abort input for pipeline flushes.

## Interface
- WIDTH, 32: operand and result width; legal values are 8 to 64.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request; sampled only while ready_o=1.
- signed_i  in  1  1: operands are two's complement (DIV/REM); 0: unsigned (DIVU/REMU).
- abort_i  in  1  cancels the operation in flight; no result is produced.
- a_i  in  WIDTH  dividend; captured on the accepting edge.
- b_i  in  WIDTH  divisor; captured on the accepting edge.
- ready_o  out  1  state==IDLE.
- valid_o  out  1  registered one-cycle pulse; results are valid this cycle.
- quotient_o  out  WIDTH  registered quotient; holds until the next result.
- remainder_o  out  WIDTH  registered remainder; holds until the next result.
- error_o  out  1  divisor was zero; updated together with valid_o.

## Operation
- States: IDLE, PREPARE, EXECUTE, FIXUP, WRITEBACK.
- Reset: state IDLE; all internal registers 0; ready_o=1; valid_o, quotient_o, remainder_o and error_o all 0.
- IDLE: start_i=1 latches a_i, b_i and signed_i, then moves to PREPARE. Otherwise stay in IDLE.
- PREPARE:
  - Form |A| and |B|; the absolute value applies only when signed_i=1 and the sign bit is set.
  - n = WIDTH - NLZ(|A|); dividend shift register = |A| << NLZ(|A|); partial remainder and quotient cleared.
  - B==0: Q = all ones, R = A, error=1; go to WRITEBACK.
  - signed_i=1, A = most-negative value, B = -1: Q = A, R = 0, error=0; go to WRITEBACK.
  - n==0 (A==0): go to FIXUP.
  - Otherwise: go to EXECUTE.
- EXECUTE, one iteration per cycle:
  - P' = {P, msb(dividend)}; the dividend shifts left.
  - D = P' - |B| is computed at WIDTH+1 bits; the sign is the MSB.
  - Sign 0: P = D and a 1 is shifted into Q. Sign 1: P = P' and a 0 is shifted into Q.
  - The counter decrements each cycle; after n iterations go to FIXUP.
- FIXUP, signed_i=1 only:
  - Q is negated when sign(A) != sign(B).
  - R is negated when A is negative. The remainder takes the dividend's sign.
- WRITEBACK: the edge that ends this cycle loads quotient_o, remainder_o and error_o, sets valid_o=1 and returns to IDLE.
- abort_i=1 in any non-IDLE state: next state is IDLE. valid_o stays 0 and the output registers are unchanged. abort_i has no effect in IDLE.
- Reset asserted mid-operation: immediate return to IDLE with reset values on all outputs.

## Timing
- Accepting edge is cycle T. PREPARE is T+1; EXECUTE is T+2 to T+1+n; FIXUP is T+2+n; WRITEBACK is T+3+n.
- valid_o is high in cycle T+4+n.
- Divide-by-zero and overflow: WRITEBACK at T+2; valid_o high in T+3.
- Worst-case latency is WIDTH+4 cycles; A=0 takes 4 cycles.
- valid_o coincides with ready_o=1. A start_i in the valid_o cycle is accepted (back-to-back operation).
- start_i while ready_o=0 is ignored and not queued.
- a_i and b_i may change freely after the accepting edge.

## Structure
- Package div_pkg holds:
  - the state enum typedef;
  - a localparam function for the counter width, $clog2(WIDTH+1).
- One sub-module, lzc_param #(WIDTH), provides the combinational leading-zero count of |A|; all-zero input gives WIDTH.
- The top-level block contains:
  - the FSM;
  - the operand, shift, partial-remainder, quotient and counter registers;
  - the WIDTH+1-bit subtractor;
  - the FIXUP negation logic.

## Test plan
- Unsigned, WIDTH=32, 100/7 -> Q=14, R=2, error=0; n=7, so valid_o at T+11.
- Signed, -7/2 -> Q=0xFFFFFFFD, R=0xFFFFFFFF. Signed 7/-2 -> Q=0xFFFFFFFD, R=1.
- B=0 with A=0x1234 -> Q=0xFFFFFFFF, R=0x1234, error=1, valid_o at T+3. Signed 0x80000000/0xFFFFFFFF -> Q=0x80000000, R=0, error=0, valid_o at T+3.
- abort_i at T+5 of a 32-iteration divide -> ready_o=1 at T+6, no valid_o, outputs keep their old values. rst_i asserted mid-EXECUTE -> all outputs 0 immediately.
- Back-to-back: a new start_i in the valid_o cycle is accepted; the second result is correct. Random unsigned and signed operands are checked against a reference model.
- WIDTH=8 instance, unsigned 255/1 -> Q=255, R=0, valid_o at T+12. WIDTH=8 signed -128/-1 -> Q=0x80, R=0.
